// File: rtl/iod_dly_pkg.sv
// Shared encodings and defaults for the IOD delay-line tap sequencer.
package iod_dly_pkg;

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_SETTLE,
      ST_LDPULSE,
      ST_FIN
   } state_e;

   localparam int TAP_MAX_DEF  = 127;
   localparam int LOAD_VAL_DEF = 1;

endpackage

// File: rtl/iod_dly_settle_timer.sv
// Down-counter that holds the sequencer in SETTLE for SETTLE_CYC cycles.
module iod_dly_settle_timer #(
   parameter int SETTLE_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire
);

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   logic [CNT_W-1:0] cnt_q;

   // Loaded with SETTLE_CYC-1 so terminal count marks the last settle cycle.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= CNT_W'(SETTLE_CYC - 1);
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/iod_dly_tap_sequencer.sv
// Arbitrates single tap commands onto the IOD delay-line MOVE/DIRECTION/LOAD pins
// and tracks every lane's tap position.
//
// state   | meaning
// IDLE    | ready for a command
// SETUP   | direction driven one cycle ahead of the first move
// PULSE   | move pulse on the selected lane (or range abort)
// SETTLE  | wait for the delay line; last cycle samples out-of-range
// LDPULSE | load pulse on the selected lane
// FIN     | done pulse with err/steps_done
module iod_dly_tap_sequencer
   import iod_dly_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int LANE_W     = $clog2(NUM_LANES),
   parameter int TAP_W      = 7,
   parameter int TAP_MAX    = TAP_MAX_DEF,
   parameter int LOAD_VAL   = LOAD_VAL_DEF,
   parameter int SETTLE_CYC = 4
) (
   input  logic                       FAB_CLK,
   input  logic                       SYNC_RST,
   input  logic                       CMD_VALID,
   output logic                       CMD_READY,
   input  logic [LANE_W-1:0]          CMD_LANE,
   input  logic [1:0]                 CMD_OP,
   input  logic [TAP_W-1:0]           CMD_STEPS,
   output logic                       DONE,
   output logic                       ERR,
   output logic [TAP_W-1:0]           STEPS_DONE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
   output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
   output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
   input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
   output logic [NUM_LANES*TAP_W-1:0] TAP_POS
);

   state_e            state;
   logic [LANE_W-1:0] lane_q;
   op_e               op_q;
   logic [TAP_W-1:0]  steps_q;
   logic [TAP_W-1:0]  pos_q [NUM_LANES];

   logic              accept;
   logic              inc;
   logic              oor;
   logic              tmr_load;
   logic              tmr_expire;
   logic [TAP_W-1:0]  cur_pos;
   logic [TAP_W-1:0]  step_pos;
   logic [TAP_W-1:0]  cnt_inc;

   function automatic logic at_limit(input logic [TAP_W-1:0] p, input logic up);
      return up ? (p == TAP_W'(TAP_MAX)) : (p == '0);
   endfunction

   assign accept   = CMD_VALID & CMD_READY;
   assign inc      = (op_q == OP_INC);
   assign cur_pos  = pos_q[lane_q];
   assign step_pos = inc ? cur_pos + 1'b1 : cur_pos - 1'b1;
   assign oor      = DELAY_LINE_OUT_OF_RANGE[lane_q];
   assign cnt_inc  = STEPS_DONE + 1'b1;
   assign tmr_load = (state == ST_PULSE) || (state == ST_LDPULSE);

   iod_dly_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle_timer (
      .clk    (FAB_CLK),
      .rst    (SYNC_RST),
      .load   (tmr_load),
      .expire (tmr_expire)
   );

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_pos
      assign TAP_POS[g*TAP_W +: TAP_W] = pos_q[g];
   end

   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state                <= ST_IDLE;
         CMD_READY            <= 1'b0;
         DONE                 <= 1'b0;
         ERR                  <= 1'b0;
         STEPS_DONE           <= '0;
         DELAY_LINE_MOVE      <= '0;
         DELAY_LINE_DIRECTION <= '0;
         DELAY_LINE_LOAD      <= '0;
         lane_q               <= '0;
         op_q                 <= OP_INC;
         steps_q              <= '0;
         for (int i = 0; i < NUM_LANES; i++) pos_q[i] <= TAP_W'(LOAD_VAL);
      end else begin
         DONE            <= 1'b0;
         DELAY_LINE_MOVE <= '0;
         DELAY_LINE_LOAD <= '0;
         case (state)
            ST_IDLE: begin
               CMD_READY <= 1'b1;
               if (accept) begin
                  CMD_READY  <= 1'b0;
                  lane_q     <= CMD_LANE;
                  op_q       <= op_e'(CMD_OP);
                  steps_q    <= CMD_STEPS;
                  STEPS_DONE <= '0;
                  case (op_e'(CMD_OP))
                     OP_LOAD: begin
                        state                     <= ST_LDPULSE;
                        DELAY_LINE_LOAD[CMD_LANE] <= 1'b1;
                     end
                     OP_RSVD: begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                        ERR   <= 1'b1;
                     end
                     default: begin
                        if (CMD_STEPS == '0) begin
                           state <= ST_FIN;
                           DONE  <= 1'b1;
                        end else begin
                           state                          <= ST_SETUP;
                           DELAY_LINE_DIRECTION[CMD_LANE] <= (op_e'(CMD_OP) == OP_INC);
                        end
                     end
                  endcase
               end
            end
            ST_SETUP: begin
               state                   <= ST_PULSE;
               DELAY_LINE_MOVE[lane_q] <= !at_limit(cur_pos, inc);
            end
            // No pulse here means the range check failed on entry.
            ST_PULSE: begin
               if (DELAY_LINE_MOVE[lane_q]) begin
                  state <= ST_SETTLE;
               end else begin
                  state <= ST_FIN;
                  DONE  <= 1'b1;
                  ERR   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (tmr_expire) begin
                  if (op_q == OP_LOAD) begin
                     state <= ST_FIN;
                     DONE  <= 1'b1;
                  end else if (oor) begin
                     state <= ST_FIN;
                     DONE  <= 1'b1;
                     ERR   <= 1'b1;
                  end else begin
                     pos_q[lane_q] <= step_pos;
                     STEPS_DONE    <= cnt_inc;
                     if (cnt_inc == steps_q) begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                     end else begin
                        state                   <= ST_PULSE;
                        DELAY_LINE_MOVE[lane_q] <= !at_limit(step_pos, inc);
                     end
                  end
               end
            end
            ST_LDPULSE: begin
               state         <= ST_SETTLE;
               pos_q[lane_q] <= TAP_W'(LOAD_VAL);
            end
            ST_FIN: begin
               state     <= ST_IDLE;
               ERR       <= 1'b0;
               CMD_READY <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
